// File: rtl/insn_encoder_if.sv
// insn_encoder_if: request and instruction-memory write bus of insn_encoder.
// The "slave" modport is the encoder. The "master" modport is the program
// generator: it drives requests and the memory-side ready, and it observes
// the write port and the status outputs.
// Signal suffixes (_i/_o) are named from the encoder's point of view.
interface insn_encoder_if #(
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  // control and request channel
  logic              start_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        cls_i;
  logic [3:0]        alusel_i;
  logic [2:0]        funct3_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [31:0]       imm_i;

  // instruction-memory write channel
  logic              wr_valid_o;
  logic              wr_ready_i;
  logic [AWIDTH-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;

  // status
  logic [CW-1:0]     count_o;
  logic              full_o;
  logic              err_o;

  modport master (
    output start_i, req_valid_i, cls_i, alusel_i, funct3_i,
           rd_i, rs1_i, rs2_i, imm_i, wr_ready_i,
    input  req_ready_o, wr_valid_o, wr_addr_o, wr_data_o,
           count_o, full_o, err_o
  );

  modport slave (
    input  start_i, req_valid_i, cls_i, alusel_i, funct3_i,
           rd_i, rs1_i, rs2_i, imm_i, wr_ready_i,
    output req_ready_o, wr_valid_o, wr_addr_o, wr_data_o,
           count_o, full_o, err_o
  );
endinterface

// File: rtl/insn_encoder.sv
// insn_encoder: sequential RV32I instruction assembler.
// Each accepted micro-op request is packed into a 32-bit instruction and
// streamed through a one-deep registered write port to instruction memory
// at an auto-incrementing address. After DEPTH words the block is full and
// refuses requests until start_i.
// Optional build macro: INSN_ENC_RANGE_CHECK_EN -- when defined, immediates
// that do not fit their instruction format make the request illegal; when
// undefined, the format's bits are taken by silent truncation.

package constants_pkg;
  // ALU operation codes (alusel_i)
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  // Instruction classes (cls_i); 9..15 are illegal
  localparam logic [3:0] CLS_LUI    = 4'd0;
  localparam logic [3:0] CLS_AUIPC  = 4'd1;
  localparam logic [3:0] CLS_JAL    = 4'd2;
  localparam logic [3:0] CLS_JALR   = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_LOAD   = 4'd5;
  localparam logic [3:0] CLS_STORE  = 4'd6;
  localparam logic [3:0] CLS_IMM    = 4'd7;
  localparam logic [3:0] CLS_REG    = 4'd8;

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
endpackage

module insn_encoder
  import constants_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter int          DEPTH     = 256,
  parameter int          AWIDTH    = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  insn_encoder_if.slave  bus
);

  localparam int                CW        = $clog2(DEPTH) + 1;
  localparam logic [AWIDTH-1:0] BASE      = AWIDTH'(BASE_ADDR);
  localparam logic [CW-1:0]     LAST_SLOT = CW'(DEPTH - 1);
  localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);

  // -------------------------------------------------------------------------
  // Request field aliases
  // -------------------------------------------------------------------------
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3_in;

  assign imm   = bus.imm_i;
  assign rd    = bus.rd_i;
  assign rs1   = bus.rs1_i;
  assign rs2   = bus.rs2_i;
  assign f3_in = bus.funct3_i;

  // -------------------------------------------------------------------------
  // Immediate range checks (only meaningful with the range-check build)
  // -------------------------------------------------------------------------
  logic i_fits;      // signed 12-bit (I and S formats)
  logic b_fits;      // signed 13-bit, even
  logic j_fits;      // signed 21-bit, even
  logic u_fits;      // low 12 bits clear
  logic sh_fits;     // shift amount 0..31

`ifdef INSN_ENC_RANGE_CHECK_EN
  // A value fits a signed N-bit field when every bit above N-2 equals the
  // sign bit, i.e. the upper bits are all ones or all zeros.
  assign i_fits  = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_fits  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign j_fits  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign u_fits  = ~(|imm[11:0]);
  assign sh_fits = ~(|imm[31:5]);
`else
  assign i_fits  = 1'b1;
  assign b_fits  = 1'b1;
  assign j_fits  = 1'b1;
  assign u_fits  = 1'b1;
  assign sh_fits = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // ALU operation decode shared by the IMM and REG classes
  // -------------------------------------------------------------------------
  logic [2:0] alu_f3;
  logic [6:0] alu_f7;
  logic       alu_shift;
  logic       alu_known;

  // Map the ALU code onto funct3/funct7 and flag shift-type operations.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before the
    // case, otherwise an unassigned path infers a latch.
    alu_f3    = 3'b000;
    alu_f7    = F7_BASE;
    alu_shift = 1'b0;
    alu_known = 1'b1;
    case (bus.alusel_i)
      ALU_ADD:  alu_f3 = 3'b000;
      ALU_SUB:  begin alu_f3 = 3'b000; alu_f7 = F7_ALT; end
      ALU_SLL:  begin alu_f3 = 3'b001; alu_shift = 1'b1; end
      ALU_SLT:  alu_f3 = 3'b010;
      ALU_SLTU: alu_f3 = 3'b011;
      ALU_XOR:  alu_f3 = 3'b100;
      ALU_SRL:  begin alu_f3 = 3'b101; alu_shift = 1'b1; end
      ALU_SRA:  begin alu_f3 = 3'b101; alu_f7 = F7_ALT; alu_shift = 1'b1; end
      ALU_OR:   alu_f3 = 3'b110;
      ALU_AND:  alu_f3 = 3'b111;
      default:  alu_known = 1'b0;   // ALU_PASS and unassigned codes
    endcase
  end

  // -------------------------------------------------------------------------
  // Instruction packing and legality
  // -------------------------------------------------------------------------
  logic [31:0] enc_word;
  logic        enc_legal;

  // Pack the request into its RV32I format and decide whether it is legal.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (bus.cls_i)
      CLS_LUI: begin
        enc_word  = {imm[31:12], rd, OP_LUI};
        enc_legal = u_fits;
      end
      CLS_AUIPC: begin
        enc_word  = {imm[31:12], rd, OP_AUIPC};
        enc_legal = u_fits;
      end
      CLS_JAL: begin
        enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        enc_legal = j_fits;
      end
      CLS_JALR: begin
        enc_word  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        enc_legal = i_fits;
      end
      CLS_BRANCH: begin
        enc_word  = {imm[12], imm[10:5], rs2, rs1, f3_in, imm[4:1], imm[11], OP_BRANCH};
        enc_legal = b_fits && (f3_in != 3'b010) && (f3_in != 3'b011);
      end
      CLS_LOAD: begin
        enc_word  = {imm[11:0], rs1, f3_in, rd, OP_LOAD};
        enc_legal = i_fits && (f3_in != 3'b011) && (f3_in != 3'b110) && (f3_in != 3'b111);
      end
      CLS_STORE: begin
        enc_word  = {imm[11:5], rs2, rs1, f3_in, imm[4:0], OP_STORE};
        enc_legal = i_fits && (f3_in inside {3'b000, 3'b001, 3'b010});
      end
      CLS_IMM: begin
        // Register-immediate shifts carry funct7 above a 5-bit shamt;
        // there is no immediate form of SUB.
        if (alu_shift) begin
          enc_word  = {alu_f7, imm[4:0], rs1, alu_f3, rd, OP_IMM};
          enc_legal = alu_known && sh_fits;
        end else begin
          enc_word  = {imm[11:0], rs1, alu_f3, rd, OP_IMM};
          enc_legal = alu_known && (bus.alusel_i != ALU_SUB) && i_fits;
        end
      end
      CLS_REG: begin
        enc_word  = {alu_f7, rs2, rs1, alu_f3, rd, OP_REG};
        enc_legal = alu_known;
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake and write-port state
  // -------------------------------------------------------------------------
  logic              wr_valid_q, wr_valid_d;
  logic [AWIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [31:0]       wr_data_q,  wr_data_d;
  logic [CW-1:0]     count_q,    count_d;
  logic              full_q,     full_d;
  logic              err_q,      err_d;

  logic accept;
  logic retire;
  logic last_slot_busy;
  logic req_ready;

  // The word in the output register already owns the final slot, so a new
  // request must wait even though full_o has not risen yet; otherwise a
  // DEPTH+1-th word could slip in on the cycle the DEPTH-th one retires.
  assign last_slot_busy = wr_valid_q && (count_q == LAST_SLOT);

  // start_i wins over everything, so no request is taken while it is high.
  assign req_ready = !bus.start_i && !full_q && !last_slot_busy &&
                     (!wr_valid_q || bus.wr_ready_i);
  assign accept    = bus.req_valid_i && req_ready;
  assign retire    = wr_valid_q && bus.wr_ready_i;

  // Next-state: retire the current word and/or load a newly accepted one.
  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    full_d     = full_q;
    err_d      = accept && !enc_legal;

    if (retire) begin
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q + AWIDTH'(4);
      count_d    = count_q + CW'(1);
      full_d     = (count_q + CW'(1)) == FULL_CNT;
    end

    // Acceptance in the same cycle as retirement refills without a bubble.
    if (accept && enc_legal) begin
      wr_valid_d = 1'b1;
      wr_data_d  = enc_word;
    end

    if (bus.start_i) begin
      wr_valid_d = 1'b0;
      wr_addr_d  = BASE;
      wr_data_d  = '0;
      count_d    = '0;
      full_d     = 1'b0;
      err_d      = 1'b0;
    end
  end

  // Registered outputs; asynchronous reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= BASE;
      wr_data_q  <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      count_q    <= count_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.wr_valid_o  = wr_valid_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.count_o     = count_q;
  assign bus.full_o      = full_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: directed plus randomized test of insn_encoder (DEPTH=4).
// Expected instruction words come from a behavioural encoder that places
// immediate slices with shift/mask arithmetic and checks ranges with signed
// integer comparisons; a negedge monitor matches every write against the
// expected-word queue and the model's address/count.
module tb_insn_encoder;
  import constants_pkg::*;

  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam int          DEPTH  = 4;
  localparam int          AWIDTH = 32;

`ifdef INSN_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  insn_encoder_if #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) bus ();

  insn_encoder #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .AWIDTH    (AWIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // model state
  logic [31:0] q_word[$];
  logic [31:0] m_addr;
  int          m_count;
  bit          rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Behavioural RV32I encoder; returns legality, word via output.
  function automatic bit model_enc(input int cls, input int alu, input int f3,
                                   input logic [31:0] rd, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm,
                                   output logic [31:0] w);
    int s;
    bit ok;
    bit alu_ok;
    bit shift;
    logic [31:0] mf3;
    logic [31:0] mf7;
    s      = $signed(imm);
    ok     = 1'b1;
    alu_ok = 1'b1;
    shift  = 1'b0;
    mf3    = 0;
    mf7    = 0;
    w      = 0;
    case (alu)
      0:  mf3 = 0;
      1:  begin mf3 = 0; mf7 = 32; end
      2:  begin mf3 = 1; shift = 1'b1; end
      3:  mf3 = 2;
      4:  mf3 = 3;
      5:  mf3 = 4;
      6:  begin mf3 = 5; shift = 1'b1; end
      7:  begin mf3 = 5; mf7 = 32; shift = 1'b1; end
      8:  mf3 = 6;
      9:  mf3 = 7;
      default: alu_ok = 1'b0;
    endcase
    case (cls)
      0, 1: begin
        w = (imm & 32'hFFFF_F000) | (rd << 7) | ((cls == 0) ? 32'h37 : 32'h17);
        if (RC && (imm % 4096) != 0) ok = 1'b0;
      end
      2: begin
        w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
            (fld(imm, 19, 12) << 12) | (rd << 7) | 32'h6F;
        if (RC && (s < -(1 << 20) || s > (1 << 20) - 1 || (s % 2) != 0)) ok = 1'b0;
      end
      3: begin
        w = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
        if (RC && (s < -2048 || s > 2047)) ok = 1'b0;
      end
      4: begin
        w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15) |
            (32'(f3) << 12) | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 32'h63;
        if (!(f3 inside {0, 1, 4, 5, 6, 7})) ok = 1'b0;
        if (RC && (s < -4096 || s > 4095 || (s % 2) != 0)) ok = 1'b0;
      end
      5: begin
        w = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (32'(f3) << 12) | (rd << 7) | 32'h03;
        if (!(f3 inside {0, 1, 2, 4, 5})) ok = 1'b0;
        if (RC && (s < -2048 || s > 2047)) ok = 1'b0;
      end
      6: begin
        w = (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (32'(f3) << 12) |
            (fld(imm, 4, 0) << 7) | 32'h23;
        if (!(f3 inside {0, 1, 2})) ok = 1'b0;
        if (RC && (s < -2048 || s > 2047)) ok = 1'b0;
      end
      7: begin
        if (!alu_ok || alu == 1) ok = 1'b0;
        if (shift) begin
          w = (mf7 << 25) | (fld(imm, 4, 0) << 20) | (rs1 << 15) | (mf3 << 12) | (rd << 7) | 32'h13;
          if (RC && imm > 31) ok = 1'b0;
        end else begin
          w = (fld(imm, 11, 0) << 20) | (rs1 << 15) | (mf3 << 12) | (rd << 7) | 32'h13;
          if (RC && (s < -2048 || s > 2047)) ok = 1'b0;
        end
      end
      8: begin
        w = (mf7 << 25) | (rs2 << 20) | (rs1 << 15) | (mf3 << 12) | (rd << 7) | 32'h33;
        if (!alu_ok) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Write monitor: a retirement happens at the next edge when valid&ready.
  always @(negedge clk) begin
    if (rst_n && !bus.start_i && bus.wr_valid_o && bus.wr_ready_i) begin
      if (q_word.size() == 0) begin
        check("write_without_expected_word", 32'(q_word.size()), 32'd1);
      end else begin
        check("wr_data", bus.wr_data_o, q_word[0]);
        check("wr_addr", bus.wr_addr_o, m_addr);
        check("count_at_write", 32'(bus.count_o), 32'(m_count));
        void'(q_word.pop_front());
        m_addr  = m_addr + 32'd4;
        m_count = m_count + 1;
      end
    end
  end

  task automatic model_clear();
    q_word.delete();
    m_addr  = BASE;
    m_count = 0;
  endtask

  // Advance one cycle; inputs change 1 unit after the edge, outputs are
  // sampled 2 units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.wr_ready_i = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic do_req(input string tag, input int cls, input int alu, input int f3,
                        input int rd, input int rs1, input int rs2, input logic [31:0] imm);
    bit          legal;
    logic [31:0] w;
    int          n;
    bus.cls_i       = 4'(cls);
    bus.alusel_i    = 4'(alu);
    bus.funct3_i    = 3'(f3);
    bus.rd_i        = 5'(rd);
    bus.rs1_i       = 5'(rs1);
    bus.rs2_i       = 5'(rs2);
    bus.imm_i       = imm;
    bus.req_valid_i = 1'b1;
    #0;
    n = 0;
    while (!bus.req_ready_o && n < 64) begin
      tick();
      n++;
    end
    if (!bus.req_ready_o) begin
      check({tag, "_ready_timeout"}, 32'(bus.req_ready_o), 32'd1);
      bus.req_valid_i = 1'b0;
      return;
    end
    legal = model_enc(cls, alu, f3, 32'(rd), 32'(rs1), 32'(rs2), imm, w);
    if (legal) q_word.push_back(w);
    tick();
    bus.req_valid_i = 1'b0;
    check({tag, "_err"}, 32'(bus.err_o), 32'(!legal));
    if (legal) check({tag, "_valid"}, 32'(bus.wr_valid_o), 32'd1);
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    model_clear();
    check("start_addr", bus.wr_addr_o, BASE);
    check("start_count", 32'(bus.count_o), 32'd0);
    check("start_full", 32'(bus.full_o), 32'd0);
    check("start_valid", 32'(bus.wr_valid_o), 32'd0);
  endtask

  task automatic drain_and_restart();
    int n;
    rand_rdy = 1'b0;
    bus.wr_ready_i = 1'b1;
    n = 0;
    while (q_word.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 32'(q_word.size()), 32'd0);
    pulse_start();
    rand_rdy = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cls, alu, f3, sel;
    logic [31:0] imm;
    logic [31:0] w;

    bus.start_i     = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.cls_i       = '0;
    bus.alusel_i    = '0;
    bus.funct3_i    = '0;
    bus.rd_i        = '0;
    bus.rs1_i       = '0;
    bus.rs2_i       = '0;
    bus.imm_i       = '0;
    bus.wr_ready_i  = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rst_valid", 32'(bus.wr_valid_o), 32'd0);
    check("rst_addr", bus.wr_addr_o, BASE);
    check("rst_data", bus.wr_data_o, 32'd0);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_full", 32'(bus.full_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_ready", 32'(bus.req_ready_o), 32'd1);

    // IMM ADD rd=1 rs1=0 imm=5: latency-1 write
    do_req("addi5", 7, ALU_ADD, 0, 1, 0, 0, 32'd5);
    check("addi5_addr", bus.wr_addr_o, BASE);
    check("addi5_data", bus.wr_data_o, 32'h0050_0093);
    bus.wr_ready_i = 1'b1;
    tick();
    check("addi5_count", 32'(bus.count_o), 32'd1);

    // REG SUB then BRANCH back to back with the memory always ready
    pulse_start();
    do_req("sub", 8, ALU_SUB, 0, 3, 1, 2, 32'd0);
    check("sub_data", bus.wr_data_o, 32'h4020_81B3);
    do_req("beq", 4, ALU_ADD, 0, 0, 1, 2, 32'd8);
    check("beq_data", bus.wr_data_o, 32'h0020_8463);
    check("beq_addr", bus.wr_addr_o, BASE + 32'd4);
    tick();
    check("pair_count", 32'(bus.count_o), 32'd2);
    check("pair_addr", bus.wr_addr_o, BASE + 32'd8);

    // JAL held stable across a 3-cycle stall
    pulse_start();
    bus.wr_ready_i = 1'b0;
    do_req("jal", 2, ALU_ADD, 0, 1, 0, 0, 32'd2048);
    for (int i = 0; i < 3; i++) begin
      check("jal_hold_valid", 32'(bus.wr_valid_o), 32'd1);
      check("jal_hold_data", bus.wr_data_o, 32'h0010_00EF);
      check("jal_hold_ready", 32'(bus.req_ready_o), 32'd0);
      tick();
    end
    bus.wr_ready_i = 1'b1;
    #1;
    check("jal_release_ready", 32'(bus.req_ready_o), 32'd1);
    tick();
    check("jal_count", 32'(bus.count_o), 32'd1);

    // IMM ADD imm=2048: out of the I range
    pulse_start();
    do_req("addi2048", 7, ALU_ADD, 0, 1, 0, 0, 32'd2048);
`ifdef INSN_ENC_RANGE_CHECK_EN
    check("addi2048_nowrite", 32'(bus.wr_valid_o), 32'd0);
`else
    check("addi2048_data", bus.wr_data_o, 32'h8000_0093);
`endif
    tick();

    // Fill to DEPTH: 4 words accepted, 5th refused until start_i
    pulse_start();
    for (int i = 0; i < DEPTH; i++)
      do_req("fill", 7, ALU_ADD, 0, i + 1, 0, 0, 32'(i));
    bus.cls_i       = 4'd7;
    bus.alusel_i    = ALU_ADD;
    bus.imm_i       = 32'd99;
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #0;
      check("fill_5th_ready", 32'(bus.req_ready_o), 32'd0);
      tick();
    end
    check("fill_full", 32'(bus.full_o), 32'd1);
    check("fill_count", 32'(bus.count_o), 32'(DEPTH));
    check("fill_addr", bus.wr_addr_o, BASE + 32'(4 * DEPTH));
    check("fill_valid", 32'(bus.wr_valid_o), 32'd0);
    bus.req_valid_i = 1'b0;
    pulse_start();

    // Illegal class and immediate SUB: err pulse, nothing written
    do_req("cls9", 9, ALU_ADD, 0, 1, 1, 1, 32'd4);
    tick();
    check("cls9_err_one_cycle", 32'(bus.err_o), 32'd0);
    do_req("isub", 7, ALU_SUB, 0, 1, 1, 1, 32'd4);
    check("illegal_valid", 32'(bus.wr_valid_o), 32'd0);
    check("illegal_addr", bus.wr_addr_o, BASE);
    check("illegal_count", 32'(bus.count_o), 32'd0);

    // Reset while a word is stalled
    bus.wr_ready_i = 1'b0;
    do_req("stall", 8, ALU_XOR, 0, 5, 6, 7, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_stall_valid", 32'(bus.wr_valid_o), 32'd0);
    check("rst_mid_stall_addr", bus.wr_addr_o, BASE);
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized requests with random memory back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (m_count + q_word.size() >= DEPTH) drain_and_restart();
      cls = int'($urandom_range(0, 10));
      alu = int'($urandom_range(0, 11));
      f3  = int'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       imm = 32'($urandom_range(0, 127)) - 32'd64;
        1:       imm = $urandom;
        2:       imm = $urandom & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 31));
      endcase
      do_req("rand", cls, alu, f3, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             int'($urandom_range(0, 31)), imm);
    end
    drain_and_restart();
    rand_rdy = 1'b0;
    check("final_queue_empty", 32'(q_word.size()), 32'd0);

    // keep the model encoder exercised for a known SRA shift form
    void'(model_enc(7, 7, 0, 32'd2, 32'd3, 32'd0, 32'd4, w));
    bus.wr_ready_i = 1'b0;
    do_req("srai", 7, ALU_SRA, 0, 2, 3, 0, 32'd4);
    check("srai_data", bus.wr_data_o, w);
    bus.wr_ready_i = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
